rlbp_scan_sequencer: RTL

- Frame-scan controller for the RLBP pixel array.
- Selects one photodiode pair at a time and drives the timing counter's start.
- For each pair, counts a programmed number of conversion cycles using the counter's clr pulse, then captures the 8-bit comparator shift register.
- Pushes each {pixel index, data} result into a small FIFO that the host drains through a ready/valid port. This replaces the manual per-pair LA selection.

---
 rtl/rlbp_pkg.sv | 40 ++++
 rtl/rlbp_res_fifo.sv | 47 ++++
 rtl/rlbp_scan_sequencer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/rlbp_pkg.sv
// Shared types and helpers for the RLBP scan sequencer.
// Holds the FSM state enum, sizing constants and the enabled-index search.
package rlbp_pkg;

  localparam int NUM_PIX_DEF = 12;
  localparam int IDX_W       = 4;
  localparam int RES_W       = 12;
  localparam logic [3:0] MAX_CYC = 4'd8;

  typedef enum logic [2:0] {IDLE, SELECT, RUN, CAPTURE, NEXT} state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } nxt_t;

  // Lowest enabled index strictly above cur, or the lowest overall when from_start is set.
  function automatic nxt_t next_en(input logic [NUM_PIX_DEF-1:0] mask,
                                   input logic [IDX_W-1:0] cur,
                                   input logic from_start);
    nxt_t r;
    r = '0;
    for (int i = NUM_PIX_DEF-1; i >= 0; i--)
      if (mask[i] && (from_start || i > int'(cur))) begin
        r.found = 1'b1;
        r.idx   = IDX_W'(i);
      end
    return r;
  endfunction

  function automatic logic [NUM_PIX_DEF-1:0] pd_onehot(input logic [IDX_W-1:0] idx);
    return NUM_PIX_DEF'(1) << idx;
  endfunction

  // Zero means the maximum; anything above the maximum saturates.
  function automatic logic [3:0] norm_cycles(input logic [3:0] c);
    return (c == 4'd0 || c > MAX_CYC) ? MAX_CYC : c;
  endfunction

endpackage

// File: rtl/rlbp_res_fifo.sv
// Result FIFO: power-of-two depth, head read straight from the storage registers.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module rlbp_res_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full,
  output logic [LVL_W-1:0] level
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign valid   = (level != '0);
  assign full    = (level == LVL_W'(DEPTH));
  assign pop_ok  = pop & valid;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
      level <= level + LVL_W'(push_ok) - LVL_W'(pop_ok);
    end
  end

endmodule

// File: rtl/rlbp_scan_sequencer.sv
// Frame-scan controller: walks enabled photodiode pairs, counts conversions,
// captures the comparator shift register and queues {idx, data} for the host.
module rlbp_scan_sequencer
  import rlbp_pkg::*;
#(
  parameter int NUM_PIX    = 12,
  parameter int SETTLE     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               go,
  input  logic               abort,
  input  logic [NUM_PIX-1:0] cfg_mask,
  input  logic [3:0]         cfg_cycles,
  input  logic               cfg_continuous,
  input  logic               conv_clr,
  input  logic [7:0]         sr_in,
  output logic [NUM_PIX-1:0] pd_a,
  output logic [NUM_PIX-1:0] pd_b,
  output logic               start,
  output logic               busy,
  output logic               frame_done,
  output logic               res_valid,
  output logic [RES_W-1:0]   res_data,
  input  logic               res_ready,
  output logic [2:0]         fifo_level
);

  state_t             state;
  logic [NUM_PIX-1:0] mask_q;
  logic [3:0]         cyc_q;
  logic               cont_q;
  logic [IDX_W-1:0]   idx;
  logic [3:0]         settle_cnt;
  logic [3:0]         cyc_cnt;
  logic               pop, push, fifo_full;
  nxt_t               nxt_hi, nxt_lo, go_lo;

  assign pd_b   = pd_a;
  assign pop    = res_ready & res_valid;
  // A discarded capture on abort must never reach the FIFO.
  assign push   = (state == CAPTURE) && (!fifo_full || pop) && !abort;
  assign nxt_hi = next_en(mask_q, idx, 1'b0);
  assign nxt_lo = next_en(mask_q, '0, 1'b1);
  assign go_lo  = next_en(cfg_mask, '0, 1'b1);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      mask_q     <= '0;
      cyc_q      <= '0;
      cont_q     <= 1'b0;
      idx        <= '0;
      settle_cnt <= '0;
      cyc_cnt    <= '0;
      pd_a       <= '0;
      start      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (abort) begin
        state <= IDLE;
        pd_a  <= '0;
        start <= 1'b0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (go) begin
            mask_q <= cfg_mask;
            cyc_q  <= norm_cycles(cfg_cycles);
            cont_q <= cfg_continuous;
            if (go_lo.found) begin
              state      <= SELECT;
              idx        <= go_lo.idx;
              pd_a       <= pd_onehot(go_lo.idx);
              settle_cnt <= 4'(SETTLE - 1);
              busy       <= 1'b1;
            end else begin
              frame_done <= 1'b1;
            end
          end
          SELECT: if (settle_cnt == 4'd0) begin
            state   <= RUN;
            start   <= 1'b1;
            cyc_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
          RUN: if (conv_clr) begin
            if (cyc_cnt + 4'd1 == cyc_q) begin
              state <= CAPTURE;
              start <= 1'b0;
            end else begin
              cyc_cnt <= cyc_cnt + 4'd1;
            end
          end
          CAPTURE: if (push) begin
            state <= NEXT;
            pd_a  <= '0;
          end
          NEXT: begin
            if (nxt_hi.found) begin
              state      <= SELECT;
              idx        <= nxt_hi.idx;
              pd_a       <= pd_onehot(nxt_hi.idx);
              settle_cnt <= 4'(SETTLE - 1);
            end else begin
              frame_done <= 1'b1;
              if (cont_q) begin
                state      <= SELECT;
                idx        <= nxt_lo.idx;
                pd_a       <= pd_onehot(nxt_lo.idx);
                settle_cnt <= 4'(SETTLE - 1);
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  rlbp_res_fifo #(.WIDTH(RES_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .push     (push),
    .din      ({idx, sr_in}),
    .pop      (pop),
    .dout     (res_data),
    .valid    (res_valid),
    .full     (fifo_full),
    .level    (fifo_level)
  );

endmodule
